// File: rtl/sample_source_pkg.sv
// sample_source_pkg
// Shared constants and types for the sample_source frame generator:
//   LFSR_TAPS   Galois feedback polynomial applied when a 1 is shifted out
//   LFSR_RESET  LFSR value after reset, also used in place of a zero seed
//   DEFAULT_N   default number of samples per frame
//   CNT_W       width of the per-frame sample counter (covers N up to 128)
//   state_t     frame FSM state encoding
package sample_source_pkg;

  localparam logic [31:0] LFSR_TAPS  = 32'h8020_0003;
  localparam logic [31:0] LFSR_RESET = 32'h0000_0001;
  localparam int          DEFAULT_N  = 100;
  localparam int          CNT_W      = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sample_source_lfsr.sv
// lfsr_galois_step
// Purely combinational single step of a right-shifting Galois LFSR.
// Ports:
//   state_i  current LFSR state
//   state_o  state after one step
module lfsr_galois_step
  import sample_source_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0] state_i,
  output logic [W-1:0] state_o
);

  // The bit falling off the bottom decides whether the taps are folded back in.
  assign state_o = {1'b0, state_i[W-1:1]} ^ (state_i[0] ? LFSR_TAPS : '0);

endmodule

// File: rtl/sample_source.sv
// sample_source
// Emits one frame of N pseudo-random samples over a valid/ready handshake
// and tracks the unsigned maximum of the samples actually transferred.
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   start     one-cycle request to begin a frame (only honoured in IDLE)
//   seed      LFSR seed captured with an accepted start (0 is replaced by 1)
//   ready     downstream can take a sample this cycle
//   valid     x holds a sample (state SEND)
//   x         current sample (the LFSR state)
//   last      x is the final sample of the frame
//   busy      frame in progress
//   done      one-cycle pulse after the final transfer
//   max_ref   maximum of samples transferred in current/most recent frame
module sample_source
  import sample_source_pkg::*;
#(
  parameter int W = 32,
  parameter int N = DEFAULT_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] seed,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] x,
  output logic         last,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] max_ref
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

  state_t           state_q, state_d;
  logic [W-1:0]     lfsr_q, lfsr_d;
  logic [W-1:0]     lfsr_next;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     max_q, max_d;
  logic             xfer;

  lfsr_galois_step #(.W(W)) u_step (
    .state_i (lfsr_q),
    .state_o (lfsr_next)
  );

  assign valid   = (state_q == ST_SEND);
  assign busy    = (state_q == ST_SEND);
  assign done    = (state_q == ST_DONE);
  assign x       = lfsr_q;
  assign last    = valid && (cnt_q == LAST_CNT);
  assign max_ref = max_q;
  assign xfer    = valid && ready;

  // Next-state logic. Everything holds unless a start is accepted in IDLE
  // or a transfer happens in SEND; the counter stops at N-1 so it never wraps.
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    cnt_d   = cnt_q;
    max_d   = max_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          lfsr_d  = (seed == '0) ? LFSR_RESET : seed;
          cnt_d   = '0;
          max_d   = '0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (xfer) begin
          lfsr_d = lfsr_next;
          if (lfsr_q > max_q) begin
            max_d = lfsr_q;
          end
          if (cnt_q == LAST_CNT) begin
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset drops any frame in flight immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      lfsr_q  <= LFSR_RESET;
      cnt_q   <= '0;
      max_q   <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      max_q   <= max_d;
    end
  end

endmodule

// File: tb/tb_sample_source.sv
// tb_sample_source
// Scoreboard bench: each accepted frame pushes its expected samples into a
// queue; an independent monitor pops and compares on every transfer.
module tb_sample_source;

  localparam int N = 100;

  typedef struct {
    logic [31:0] x;
    logic        last;
  } expect_t;

  logic        clock;
  logic        reset;
  logic        start;
  logic [31:0] seed;
  logic        ready;
  logic        valid;
  logic [31:0] x;
  logic        last;
  logic        busy;
  logic        done;
  logic [31:0] maxRef;

  int checks;
  int errors;
  int cycle;
  int doneCount;
  int doneCycle;
  int transferCount;
  expect_t expQ[$];

  sample_source #(.W(32), .N(N)) dut (
    .clk     (clock),
    .rst     (reset),
    .start   (start),
    .seed    (seed),
    .ready   (ready),
    .valid   (valid),
    .x       (x),
    .last    (last),
    .busy    (busy),
    .done    (done),
    .max_ref (maxRef)
  );

  // Free-running clock and cycle index used for latency measurements.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at cycle %0d", name, actual, expected, cycle);
    end
  endtask

  // Reference model: the sample stream is the seed (zero treated as one)
  // followed by repeated Galois steps; pushes one entry per sample and
  // returns the largest sample value.
  function automatic logic [31:0] buildFrame(input logic [31:0] s);
    logic [31:0] v;
    logic [31:0] m;
    v = (s == 0) ? 32'd1 : s;
    m = 0;
    for (int i = 0; i < N; i++) begin
      expQ.push_back('{x: v, last: (i == N - 1)});
      if (v > m) m = v;
      v = (v >> 1) ^ (v[0] ? 32'h8020_0003 : 32'h0);
    end
    return m;
  endfunction

  // Monitor: samples half a cycle away from the active edge.
  initial begin
    logic        holdPrev;
    logic [31:0] prevX;
    logic        prevLast;
    expect_t     e;
    holdPrev = 1'b0;
    prevX    = '0;
    prevLast = 1'b0;
    forever begin
      @(negedge clock);
      if (reset) begin
        holdPrev = 1'b0;
      end else begin
        if (holdPrev) begin
          checkOutput("hold_x", x, prevX);
          checkOutput("hold_last", {31'b0, last}, {31'b0, prevLast});
        end
        if (done) begin
          doneCount++;
          doneCycle = cycle;
          checkOutput("done_valid", {31'b0, valid}, 32'd0);
        end
        if (valid && ready) begin
          transferCount++;
          if (expQ.size() == 0) begin
            checkOutput("unexpected_xfer", 32'd1, 32'd0);
          end else begin
            e = expQ.pop_front();
            checkOutput("x", x, e.x);
            checkOutput("last", {31'b0, last}, {31'b0, e.last});
          end
        end
        holdPrev = valid && !ready;
        prevX    = x;
        prevLast = last;
      end
    end
  end

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_valid"}, {31'b0, valid}, 32'd0);
    checkOutput({tag, "_last"},  {31'b0, last},  32'd0);
    checkOutput({tag, "_busy"},  {31'b0, busy},  32'd0);
    checkOutput({tag, "_done"},  {31'b0, done},  32'd0);
    checkOutput({tag, "_x"},     x,              32'd1);
    checkOutput({tag, "_max"},   maxRef,         32'd0);
  endtask

  // Runs one complete frame. mode 0: ready held high, 1: ready toggles,
  // 2: random ready. midStart pulses start (new seed) halfway through.
  task automatic applyStimulus(input logic [31:0] s, input int mode, input bit midStart);
    logic [31:0] expMax;
    int          startCyc;
    int          baseDone;
    int          baseXfer;
    int          guard;
    bit          midDone;
    baseDone = doneCount;
    baseXfer = transferCount;
    midDone  = 1'b0;
    @(posedge clock); #1;
    seed     = s;
    start    = 1'b1;
    ready    = 1'b1;
    startCyc = cycle;
    expMax   = buildFrame(s);
    guard    = 0;
    @(posedge clock); #1;
    start = 1'b0;
    seed  = $urandom;
    while (doneCount == baseDone && guard < 8 * N + 50) begin
      case (mode)
        1:       ready = ~ready;
        2:       ready = ($urandom_range(0, 3) != 0);
        default: ready = 1'b1;
      endcase
      if (midStart && !midDone && (transferCount - baseXfer) >= 50) begin
        start   = 1'b1;
        midDone = 1'b1;
      end else begin
        start = 1'b0;
      end
      guard++;
      @(posedge clock); #1;
    end
    start = 1'b0;
    if (doneCount == baseDone) checkOutput("frame_timeout", 32'd0, 32'd1);
    if (mode == 0) checkOutput("done_latency", doneCycle - startCyc, N + 1);
    repeat (6) @(posedge clock);
    @(negedge clock);
    checkOutput("xfers_per_frame", transferCount - baseXfer, N);
    checkOutput("done_pulses", doneCount - baseDone, 32'd1);
    checkOutput("queue_empty", expQ.size(), 32'd0);
    checkOutput("idle_busy", {31'b0, busy}, 32'd0);
    checkOutput("max_ref", maxRef, expMax);
  endtask

  // Aborts a frame with reset after 40 transfers, then restarts.
  task automatic abortTest(input logic [31:0] s);
    int          baseDone;
    int          baseXfer;
    int          guard;
    logic [31:0] discard;
    baseDone = doneCount;
    baseXfer = transferCount;
    @(posedge clock); #1;
    seed    = s;
    start   = 1'b1;
    ready   = 1'b1;
    discard = buildFrame(s);
    @(posedge clock); #1;
    start = 1'b0;
    guard = 0;
    while ((transferCount - baseXfer) < 40 && guard < 500) begin
      @(negedge clock);
      guard++;
    end
    if ((transferCount - baseXfer) < 40) checkOutput("abort_timeout", 32'd0, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    checkResetValues("abort");
    expQ.delete();
    @(posedge clock); #3;
    reset = 1'b0;
    repeat (20) @(posedge clock);
    @(negedge clock);
    checkOutput("abort_no_done", doneCount - baseDone, 32'd0);
    checkOutput("abort_stays_idle", {31'b0, valid}, 32'd0);
    applyStimulus($urandom, 0, 1'b0);
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    cycle         = 0;
    doneCount     = 0;
    doneCycle     = 0;
    transferCount = 0;
    reset = 1'b1;
    start = 1'b0;
    seed  = '0;
    ready = 1'b0;
    #3;
    checkResetValues("reset");
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    applyStimulus(32'd1, 0, 1'b0);
    // max_ref must survive a stretch of IDLE
    repeat (30) @(posedge clock);
    @(negedge clock);
    checkOutput("max_hold_idle", maxRef, buildFrameMax(32'd1));

    applyStimulus(32'd0, 0, 1'b0);
    applyStimulus(32'd1, 1, 1'b0);
    applyStimulus($urandom, 0, 1'b1);
    abortTest($urandom);
    for (int i = 0; i < 2; i++) applyStimulus($urandom, 2, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Maximum of a seed's frame without touching the scoreboard queue.
  function automatic logic [31:0] buildFrameMax(input logic [31:0] s);
    logic [31:0] v;
    logic [31:0] m;
    v = (s == 0) ? 32'd1 : s;
    m = 0;
    for (int i = 0; i < N; i++) begin
      if (v > m) m = v;
      v = (v >> 1) ^ (v[0] ? 32'h8020_0003 : 32'h0);
    end
    return m;
  endfunction

endmodule

// File: doc/sample_source.md
SAMPLE_SOURCE -- requirements
Module: sample_source

Interface
REQ-001 Parameter W, default 32, sample width in bits; only W=32 is supported.
REQ-002 Parameter N, default 100, samples per frame; 2 <= N <= 128.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  one-cycle request to begin a frame.
REQ-006 seed  input  W  LFSR seed, sampled in the cycle start is accepted.
REQ-007 ready  input  1  downstream consumer can accept a sample this cycle.
REQ-008 valid  output  1  x holds a valid sample.
REQ-009 x  output  W  current sample.
REQ-010 last  output  1  x is the final sample of the frame.
REQ-011 busy  output  1  a frame is in progress (state SEND).
REQ-012 done  output  1  one-cycle pulse after the last sample transfers.
REQ-013 max_ref  output  W  unsigned maximum of samples transferred in the current or most recent frame.

Function
REQ-014 The FSM SHALL have states IDLE, SEND and DONE.
REQ-015 In IDLE, start=1 SHALL load the LFSR with seed (or 1 if seed==0), clear the sample counter to 0, clear max_ref to 0 and move to SEND on the next edge.
REQ-016 In SEND, valid SHALL be 1 and x SHALL equal the LFSR state.
REQ-017 A transfer SHALL occur on a clock edge where valid=1 and ready=1.
REQ-018 On a transfer the LFSR SHALL step once: Galois right-shift, XOR with taps 0x80200003 when the shifted-out bit is 1.
REQ-019 On a transfer, max_ref SHALL update to the larger of max_ref and x (unsigned).
REQ-020 On a transfer, the 7-bit counter SHALL increment.
REQ-021 While valid=1 and ready=0, x, last and the counter SHALL hold stable.
REQ-022 last SHALL equal valid AND (counter == N-1).
REQ-023 A transfer with last=1 SHALL move the FSM to DONE; the counter SHALL NOT wrap past N-1.
REQ-024 DONE SHALL last exactly one cycle with done=1 and valid=0, then return to IDLE.
REQ-025 start SHALL be ignored in SEND and DONE.
REQ-026 max_ref SHALL hold its value in IDLE until the next accepted start.
REQ-027 Latency: first valid=1 in the cycle after start is accepted; with ready held at 1, done=1 exactly N+1 cycles after start.
REQ-028 Exactly N transfers SHALL occur per frame.

Reset
REQ-029 rst=1 SHALL immediately force state IDLE, LFSR=1, counter=0 and max_ref=0; valid, last, busy and done SHALL be 0 and x SHALL be 1.
REQ-030 A reset asserted mid-frame SHALL abort the frame with no done pulse; the next frame requires a new start.

Structure
REQ-031 The LFSR taps constant, the state encodings and the default N SHALL reside in the shared header sample_source_pkg.
REQ-032 The LFSR step SHALL be a combinational sub-module lfsr_galois_step (W in, W out).
REQ-033 All registers SHALL use the codebase's asynchronous-reset register and counter macros.

Verification
REQ-034 seed=1, ready=1, start pulse -> x sequence 0x00000001, 0x80200003, 0xC0300002...; last on transfer 100; done pulse at cycle 101.
REQ-035 seed=0 -> first x=0x00000001, identical to seed=1.
REQ-036 ready toggling 1,0,1,0 -> x stable during every ready=0 cycle; 100 transfers total; transferred samples identical to the ready=1 run.
REQ-037 start pulsed in cycle 50 of a frame -> no effect; frame completes normally with one done pulse.
REQ-038 rst asserted at transfer 40 -> outputs reach reset values within the same cycle; no done pulse; a new start restarts from the new seed.
REQ-039 Full frame with seed=1 -> max_ref equals the software-model maximum of the 100 samples and holds through IDLE.
